peripheral_display_ctrl: RTL and testbench

// - Memory-mapped display controller for the ARM single-cycle SoC. Accepts a signed 32-bit word

---
 rtl/display_pkg.sv | 23 ++
 rtl/bcd_dd_step.sv | 30 +++
 rtl/peripheral_display_ctrl.sv | 158 +++++++++++++++
 tb/tb_peripheral_display_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants, FSM state type and helpers for the display controller
// Purpose: digit code constants, FSM state encoding, decimal power helper.
package display_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_DASH  = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    FORMAT = 2'd3
  } disp_state_t;

  // 10**n, used only to build elaboration-time range limits.
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// rtl/bcd_dd_step.sv - one combinational double-dabble step (add-3 then shift left)
// Purpose: adjusts every BCD nibble >= 5 by +3, then shifts {bcd,bin} left by one.
// Ports:
//   i_bcd [4*NDIG-1:0]  BCD accumulator before the step
//   i_bin [MAG_W-1:0]   remaining binary bits before the step
//   o_bcd [4*NDIG-1:0]  BCD accumulator after the step
//   o_bin [MAG_W-1:0]   remaining binary bits after the step
module bcd_dd_step #(
  parameter int NDIG  = 6,
  parameter int MAG_W = 20
) (
  input  logic [4*NDIG-1:0] i_bcd,
  input  logic [MAG_W-1:0]  i_bin,
  output logic [4*NDIG-1:0] o_bcd,
  output logic [MAG_W-1:0]  o_bin
);

  logic [4*NDIG-1:0] w_adj;

  always_comb begin
    w_adj = i_bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (i_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
    end
  end

  // The bit shifted out of the top nibble is always 0 for in-range magnitudes.
  assign {o_bcd, o_bin} = {w_adj, i_bin} << 1;

endmodule

// File: rtl/peripheral_display_ctrl.sv
// rtl/peripheral_display_ctrl.sv - memory-mapped signed-decimal 7-segment display controller
// Purpose: converts a CPU-written signed 32-bit word to sign-magnitude BCD digit codes
//          with a sequential double-dabble engine, blanking and overflow indication.
// Ports:
//   clk, nreset              clock (rising edge), async active-low reset
//   wr_en, wr_data[31:0]     single-cycle store strobe and two's-complement value
//   busy                     conversion in progress
//   done                     one-cycle pulse when new digits become valid
//   digit_code[4*NDIG-1:0]   digit i code at [4i+3:4i], digit 0 rightmost
//   digit_ext[NDIG-1:0]      per-digit EXTENDED flag, held at 0
module peripheral_display_ctrl
  import display_pkg::*;
#(
  parameter int NDIG  = 6,
  parameter int MAG_W = 20
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] digit_code,
  output logic [NDIG-1:0]   digit_ext
);

  localparam int CW    = 4 * NDIG;
  localparam int CNT_W = $clog2(MAG_W);
  // One digit is reserved for the minus sign, hence the narrower negative range.
  localparam logic signed [63:0] MAX_POS = 64'(pow10(NDIG) - 1);
  localparam logic signed [63:0] MIN_NEG = 64'(1 - pow10(NDIG - 1));

  disp_state_t        r_state;
  disp_state_t        w_next;
  logic [31:0]        r_val;
  logic               r_pend_v;
  logic [31:0]        r_pend_data;
  logic               r_neg;
  logic               r_ovf;
  logic [CW-1:0]      r_bcd;
  logic [MAG_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_cnt;
  logic [CW-1:0]      r_digit_code;
  logic               r_done;

  logic [31:0]        w_src;
  logic signed [63:0] w_val_ext;
  logic               w_ovf;
  logic [MAG_W-1:0]   w_mag;
  logic [CW-1:0]      w_step_bcd;
  logic [MAG_W-1:0]   w_step_bin;
  logic [CW-1:0]      w_fmt;
  logic               w_last_shift;

  bcd_dd_step #(
    .NDIG  (NDIG),
    .MAG_W (MAG_W)
  ) u_step (
    .i_bcd (r_bcd),
    .i_bin (r_bin),
    .o_bcd (w_step_bcd),
    .o_bin (w_step_bin)
  );

  // A fresh write in IDLE takes priority over a stale pending word.
  assign w_src        = wr_en ? wr_data : r_pend_data;
  assign w_val_ext    = signed'({{32{r_val[31]}}, r_val});
  assign w_ovf        = (w_val_ext > MAX_POS) || (w_val_ext < MIN_NEG);
  // 32'h8000_0000 negates to itself; it is always overflow so the truncated value is unused.
  assign w_mag        = MAG_W'(r_val[31] ? (~r_val + 32'd1) : r_val);
  assign w_last_shift = (r_cnt == CNT_W'(MAG_W - 1));

  // Formatting: blank leading zeros, keep digit 0, place the dash left of the MSD.
  always_comb begin
    int msd;
    msd   = 0;
    w_fmt = {NDIG{DIG_BLANK}};
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) msd = i;
    end
    for (int i = 0; i < NDIG; i++) begin
      if (r_ovf)                        w_fmt[4*i +: 4] = DIG_DASH;
      else if (i <= msd)                w_fmt[4*i +: 4] = r_bcd[4*i +: 4];
      else if (r_neg && (i == msd + 1)) w_fmt[4*i +: 4] = DIG_DASH;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // FSM next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (wr_en || r_pend_v) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_last_shift) w_next = FORMAT;
      FORMAT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy       = (r_state != IDLE);
    done       = r_done;
    digit_code = r_digit_code;
    digit_ext  = '0;
  end

  // Datapath: source capture, pending slot, conversion registers, output latch
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_val        <= '0;
      r_pend_v     <= 1'b0;
      r_pend_data  <= '0;
      r_neg        <= 1'b0;
      r_ovf        <= 1'b0;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_cnt        <= '0;
      r_digit_code <= {NDIG{DIG_BLANK}};
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == FORMAT);

      if (r_state == IDLE) begin
        if (wr_en || r_pend_v) r_val <= w_src;
        r_pend_v <= 1'b0;
      end else if (wr_en) begin
        // Latest write while busy wins; includes the FORMAT cycle.
        r_pend_v    <= 1'b1;
        r_pend_data <= wr_data;
      end

      case (r_state)
        LOAD: begin
          r_neg <= r_val[31];
          r_ovf <= w_ovf;
          r_bin <= w_mag;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_bcd <= w_step_bcd;
          r_bin <= w_step_bin;
          r_cnt <= r_cnt + 1'b1;
        end
        FORMAT:  r_digit_code <= w_fmt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_display_ctrl.sv
// tb/tb_peripheral_display_ctrl.sv - self-checking bench for peripheral_display_ctrl
module tb_peripheral_display_ctrl;

  logic        clk;
  logic        nreset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [23:0] digit_code;
  logic [5:0]  digit_ext;

  int errors;
  int checks;
  logic [23:0] last_expect;

  peripheral_display_ctrl dut (
    .clk        (clk),
    .nreset     (nreset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .digit_code (digit_code),
    .digit_ext  (digit_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by repeated division, sign placed above the top digit.
  function automatic logic [23:0] model(input logic [31:0] w);
    longint v;
    longint mag;
    int n;
    logic [23:0] r;
    v = longint'($signed(w));
    if (v > 999999 || v < -99999) return {6{4'hB}};
    r   = {6{4'hF}};
    mag = (v < 0) ? -v : v;
    n   = 0;
    do begin
      r[4*n +: 4] = 4'(mag % 10);
      mag = mag / 10;
      n++;
    end while (mag != 0);
    if (v < 0) r[4*n +: 4] = 4'hB;
    return r;
  endfunction

  task automatic write_word(input logic [31:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  // Steps clock until done; checks outputs hold the previous value meanwhile.
  task automatic wait_done(output int cyc);
    bit held;
    held = 1'b1;
    cyc  = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
      if (digit_code !== last_expect) held = 1'b0;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL hold: digit_code changed before done (now %h, required %h until done)", digit_code, last_expect);
    end
  endtask

  task automatic convert_check(input logic [31:0] v);
    int cyc;
    logic [23:0] exp;
    exp = model(v);
    write_word(v);
    wait_done(cyc);
    checks++;
    if (cyc !== 22) begin
      errors++;
      $display("FAIL latency %h: got %0d required 22", v, cyc);
    end
    checks++;
    if (digit_code !== exp) begin
      errors++;
      $display("FAIL digits %h: got %h required %h", v, digit_code, exp);
    end
    checks++;
    if (digit_ext !== 6'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ext_busy %h: ext=%b busy=%b required ext=0 busy=0", v, digit_ext, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse %h: done=%b on second cycle, required 0", v, done);
    end
    last_expect = exp;
  endtask

  task automatic test_reset();
    nreset  = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (digit_code !== 24'hFFFFFF || digit_ext !== 6'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: code=%h ext=%b busy=%b done=%b required FFFFFF/0/0/0", digit_code, digit_ext, busy, done);
    end
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    last_expect = 24'hFFFFFF;
  endtask

  task automatic test_directed();
    convert_check(32'd0);
    convert_check(32'd1234);
    convert_check(-32'sd42);
  endtask

  task automatic test_boundaries();
    convert_check(32'd999999);
    convert_check(32'd1000000);
    convert_check(-32'sd99999);
    convert_check(-32'sd100000);
    convert_check(32'h8000_0000);
    convert_check(32'h7FFF_FFFF);
  endtask

  task automatic test_pending();
    int pulses;
    bit saw8;
    logic [23:0] shown [2];
    pulses = 0;
    saw8   = 1'b0;
    shown[0] = '0;
    shown[1] = '0;
    write_word(32'd7);
    repeat (4) @(posedge clk);
    #1;
    write_word(32'd8);
    repeat (5) @(posedge clk);
    #1;
    write_word(32'd9);
    for (int i = 0; i < 90; i++) begin
      @(posedge clk);
      #1;
      if (digit_code === model(32'd8)) saw8 = 1'b1;
      if (done) begin
        if (pulses < 2) shown[pulses] = digit_code;
        pulses++;
      end
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL pend_pulses: got %0d required 2", pulses);
    end
    checks++;
    if (shown[0] !== model(32'd7) || shown[1] !== model(32'd9)) begin
      errors++;
      $display("FAIL pend_values: got %h,%h required %h,%h", shown[0], shown[1], model(32'd7), model(32'd9));
    end
    checks++;
    if (saw8) begin
      errors++;
      $display("FAIL pend_overwrite: value 8 was displayed, required never");
    end
    last_expect = model(32'd9);
  endtask

  task automatic test_back_to_back();
    int cyc;
    write_word(32'd5);
    // Land the second write on the edge that leaves FORMAT.
    repeat (21) @(posedge clk);
    #1;
    write_word(32'd6);
    checks++;
    if (done !== 1'b1 || digit_code !== model(32'd5)) begin
      errors++;
      $display("FAIL b2b_first: done=%b code=%h required 1/%h", done, digit_code, model(32'd5));
    end
    last_expect = model(32'd5);
    wait_done(cyc);
    checks++;
    if (cyc !== 23 || digit_code !== model(32'd6)) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d code=%h required 23/%h", cyc, digit_code, model(32'd6));
    end
    last_expect = model(32'd6);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 1'b0;
    write_word(32'd555);
    repeat (11) @(posedge clk);
    #1;
    nreset = 1'b0;
    #1;
    checks++;
    if (digit_code !== 24'hFFFFFF || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: code=%h busy=%b done=%b required FFFFFF/0/0", digit_code, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_abort: done/busy seen after reset, required none");
    end
    last_expect = 24'hFFFFFF;
    convert_check(32'd3);
  endtask

  task automatic test_random();
    int sel;
    logic [31:0] v;
    for (int k = 0; k < 16; k++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       v = $urandom;
        1:       v = 32'($urandom_range(0, 1100000));
        2:       v = 32'(-int'($urandom_range(0, 120000)));
        default: v = 32'($urandom_range(0, 999));
      endcase
      convert_check(v);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    last_expect = 24'hFFFFFF;
    test_reset();
    test_directed();
    test_boundaries();
    test_pending();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
